// File: rtl/s_pl_elastic.sv
// s_pl_elastic: DEPTH-stage elastic valid/ready pipeline with per-stage skid slots, flush and occupancy.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ivld, irdy, idat    : upstream handshake and data
//   ovld, ordy, odat    : downstream handshake and data
//   flush               : synchronous discard of all held words
//   occ                 : number of words currently held (0..2*DEPTH)
module s_pl_elastic #(
    parameter int SIZE = 8,
    parameter int DEPTH = 2,
    parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}},
    parameter int CNT_W = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ivld,
    output logic             irdy,
    input  logic [SIZE-1:0]  idat,
    output logic             ovld,
    input  logic             ordy,
    output logic [SIZE-1:0]  odat,
    input  logic             flush,
    output logic [CNT_W-1:0] occ
);
    logic [DEPTH-1:0] mv, sv;
    logic [SIZE-1:0]  md [DEPTH];
    logic             en;
    // en keeps irdy low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) en <= 1'b0;
        else en <= 1'b1;
    assign irdy = en & ~sv[0];
    assign ovld = mv[DEPTH-1];
    assign odat = md[DEPTH-1];
    for (genvar k = 0; k < DEPTH; k++) begin : g_st
        logic            in_v, take, m_v, s_v;
        logic [SIZE-1:0] in_d, m_d, s_d;
        if (k == 0) begin : g_in
            assign in_v = ivld & irdy;
            assign in_d = idat;
        end else begin : g_mid
            // upstream's main slot moves here whenever our skid slot is free
            assign in_v = mv[k-1] & ~sv[k];
            assign in_d = md[k-1];
        end
        if (k == DEPTH-1) begin : g_last
            assign take = m_v & ordy;
        end else begin : g_take
            assign take = m_v & ~sv[k+1];
        end
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                m_v <= 1'b0;
                s_v <= 1'b0;
                m_d <= RST_VAL;
                s_d <= RST_VAL;
            end else if (flush) begin
                m_v <= 1'b0;
                s_v <= 1'b0;
                m_d <= RST_VAL;
                s_d <= RST_VAL;
            end else if (!m_v || take) begin
                if (s_v) begin
                    m_v <= 1'b1;
                    m_d <= s_d;
                    s_v <= 1'b0;
                end else begin
                    m_v <= in_v;
                    if (in_v) m_d <= in_d;
                end
            end else if (in_v) begin
                // main slot is stuck: park the arriving word, ready drops next cycle
                s_v <= 1'b1;
                s_d <= in_d;
            end
        assign mv[k] = m_v;
        assign sv[k] = s_v;
        assign md[k] = m_d;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) occ <= '0;
        else if (flush) occ <= '0;
        else occ <= occ + CNT_W'(ivld & irdy) - CNT_W'(ovld & ordy);
endmodule

// File: tb/tb_s_pl_elastic.sv
// tb_s_pl_elastic: scoreboard-checked bench for s_pl_elastic (DEPTH=3 and DEPTH=1 builds).
module tb_s_pl_elastic;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic ivld, irdy, ovld, ordy, flush;
    logic [7:0] idat, odat;
    logic [2:0] occ;
    logic ivld1, irdy1, ovld1, ordy1;
    logic [7:0] idat1, odat1;
    logic [1:0] occ1;
    s_pl_elastic #(.SIZE(8), .DEPTH(3), .RST_VAL(8'hA5)) u3 (
        .clk(clk), .rst_n(rst_n), .ivld(ivld), .irdy(irdy), .idat(idat),
        .ovld(ovld), .ordy(ordy), .odat(odat), .flush(flush), .occ(occ));
    s_pl_elastic #(.SIZE(8), .DEPTH(1), .RST_VAL(8'hA5)) u1 (
        .clk(clk), .rst_n(rst_n), .ivld(ivld1), .irdy(irdy1), .idat(idat1),
        .ovld(ovld1), .ordy(ordy1), .odat(odat1), .flush(1'b0), .occ(occ1));
    int checks = 0, errors = 0;
    logic [7:0] q[$];
    int ncnt = 0, acc_cnt = 0, out_cnt = 0, acc_n = -1, ov_n = -1;
    bit lat_arm = 0, prev_hold = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    // reference model: FIFO of accepted words, checked every cycle
    always @(negedge clk) begin
        ncnt++;
        if (!rst_n) begin
            chk("rst_ovld", ovld, 0);
            chk("rst_occ", occ, 0);
            q.delete();
            prev_hold = 0;
        end else begin
            chk("occ_vs_model", occ, q.size());
            chk("occ_range", occ <= 6, 1);
            if (prev_hold) chk("hold_ovld", ovld, 1);
            if (ovld) begin
                if (q.size() == 0) chk("ovld_spurious", ovld, 0);
                else chk("odat_vs_model", odat, q[0]);
            end
            if (q.size() == 0) chk("irdy_when_empty", irdy, 1);
            prev_hold = ovld && !ordy && !flush;
            if (ovld && ordy) begin
                if (q.size() != 0) void'(q.pop_front());
                out_cnt++;
            end
            if (ivld && irdy) begin
                acc_cnt++;
                if (lat_arm && acc_n < 0) acc_n = ncnt;
                q.push_back(idat);
            end
            if (flush) q.delete();
            if (lat_arm && ovld && ov_n < 0) ov_n = ncnt;
        end
    end
    initial begin
        bit got;
        int a, n, ln, fa, fo;
        logic [7:0] e;
        ivld = 0; ordy = 0; flush = 0; idat = 0;
        ivld1 = 0; ordy1 = 0; idat1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("irdy_in_reset", irdy, 0);
        chk("odat_in_reset", odat, 8'hA5);
        #1 rst_n = 1;
        cyc();
        chk("irdy_after_reset", irdy, 1);
        chk("odat_after_reset", odat, 8'hA5);
        chk("occ_after_reset", occ, 0);
        chk("ovld_after_reset", ovld, 0);
        chk("d1_odat_reset", odat1, 8'hA5);
        chk("d1_occ_reset", occ1, 0);
        // streaming
        lat_arm = 1; acc_n = -1; ov_n = -1; out_cnt = 0;
        ordy = 1; ivld = 1;
        for (int i = 1; i <= 16; i++) begin
            idat = 8'(i);
            @(negedge clk);
            chk("stream_irdy", irdy, 1);
            if (i >= 5) chk("stream_occ", occ, 3);
            cyc();
        end
        ivld = 0;
        repeat (8) cyc();
        chk("stream_latency", ov_n - acc_n, 3);
        chk("stream_count", out_cnt, 16);
        lat_arm = 0;
        // backpressure fill
        ordy = 0; ivld = 1; acc_cnt = 0; out_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            idat = 8'h20 + 8'(i);
            @(negedge clk);
            chk("fill_irdy", irdy, acc_cnt < 6);
            cyc();
        end
        chk("fill_accepts", acc_cnt, 6);
        chk("fill_occ", occ, 6);
        chk("fill_ovld", ovld, 1);
        chk("fill_odat", odat, 8'h20);
        chk("fill_irdy_low", irdy, 0);
        ivld = 0; ordy = 1;
        cyc();
        got = 0;
        for (int j = 0; j < 3 && !got; j++) begin
            @(negedge clk);
            got = irdy;
            if (!got) cyc();
        end
        chk("drain_irdy_reassert", got, 1);
        repeat (8) cyc();
        chk("drain_count", out_cnt, 6);
        chk("drain_occ", occ, 0);
        // flush with 4 held words and an input in the same cycle
        ordy = 0; ivld = 1;
        for (int i = 0; i < 4; i++) begin
            idat = 8'h40 + 8'(i);
            cyc();
        end
        idat = 8'hEE; flush = 1;
        @(negedge clk);
        chk("preflush_occ", occ, 4);
        cyc();
        flush = 0; ivld = 0;
        @(negedge clk);
        chk("flush_ovld", ovld, 0);
        chk("flush_occ", occ, 0);
        chk("flush_irdy", irdy, 1);
        chk("flush_odat", odat, 8'hA5);
        ordy = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_no_ghost", ovld, 0);
            cyc();
        end
        // asynchronous reset mid-stream
        ordy = 0; ivld = 1;
        for (int i = 0; i < 3; i++) begin
            idat = 8'h50 + 8'(i);
            cyc();
        end
        ivld = 0;
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("async_rst_ovld", ovld, 0);
        chk("async_rst_occ", occ, 0);
        chk("async_rst_odat", odat, 8'hA5);
        chk("async_rst_irdy", irdy, 0);
        @(negedge clk);
        #2 rst_n = 1;
        cyc();
        chk("irdy_after_rerelease", irdy, 1);
        // randomized traffic
        for (int i = 0; i < 10000; i++) begin
            ivld = ($urandom % 4) != 0;
            ordy = (i < 5000) ? (($urandom % 3) != 0) : (($urandom % 3) == 0);
            flush = ($urandom % 256) == 0;
            idat = 8'($urandom);
            cyc();
        end
        flush = 0; ivld = 0; ordy = 1;
        repeat (10) cyc();
        chk("random_drain_occ", occ, 0);
        // DEPTH=1 build: capacity 2
        ordy1 = 0; ivld1 = 1; a = 0;
        for (int i = 0; i < 5; i++) begin
            idat1 = 8'h60 + 8'(i);
            @(negedge clk);
            if (ivld1 && irdy1) a++;
            cyc();
        end
        chk("d1_fill_accepts", a, 2);
        chk("d1_fill_occ", occ1, 2);
        chk("d1_fill_ovld", ovld1, 1);
        chk("d1_fill_odat", odat1, 8'h60);
        chk("d1_fill_irdy", irdy1, 0);
        ivld1 = 0; ordy1 = 1; e = 8'h60; n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ovld1 && ordy1) begin
                chk("d1_drain_data", odat1, e);
                e++; n++;
            end
            cyc();
        end
        chk("d1_drain_count", n, 2);
        // DEPTH=1 build: streaming, latency 1
        e = 8'h70; n = 0; ln = 0; fa = -1; fo = -1;
        for (int i = 0; i < 12; i++) begin
            ivld1 = i < 8;
            idat1 = 8'h70 + 8'(i);
            @(negedge clk);
            if (i < 8) chk("d1_stream_irdy", irdy1, 1);
            if (ivld1 && irdy1 && fa < 0) fa = ln;
            if (ovld1 && fo < 0) fo = ln;
            if (ovld1) begin
                chk("d1_stream_data", odat1, e);
                e++; n++;
            end
            ln++;
            cyc();
        end
        chk("d1_stream_latency", fo - fa, 1);
        chk("d1_stream_count", n, 8);
        chk("d1_stream_occ", occ1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
